// File: rtl/packet_stream_decoder.sv
// Packet decoder for the UART word stream: SOP, command, length, then payload words.
// All outputs registered; resync has priority in every state; inter-word timeout.
module packet_stream_decoder #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned CMD_W       = 2,
  parameter int unsigned CMD_LSB     = 24,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter bit          LEN_SWAP    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [WORD_W-1:0] RESYNC_WORD = 32'h1EDC6F41,
  parameter logic [WORD_W-1:0] SOP_WORD    = 32'h741B8CD7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word_data,
  output logic [CMD_W-1:0]  o_cmd,
  output logic              o_cmd_valid,
  output logic [WORD_W-1:0] o_payload_data,
  output logic              o_payload_valid,
  output logic              o_packet_done,
  output logic              o_resync,
  output logic              o_err_len,
  output logic              o_err_timeout,
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CMD     = 2'd1;
  localparam logic [1:0] S_LEN     = 2'd2;
  localparam logic [1:0] S_PAYLOAD = 2'd3;

  localparam int unsigned TO_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
  localparam bit          TO_EN    = (TIMEOUT_CYC != 0);

  // Length field extraction, optionally byte-reversed for little-endian senders.
  function automatic logic [LEN_W-1:0] len_of(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    if (LEN_SWAP) begin
      for (int unsigned b = 0; b < WORD_W / 8; b++) begin
        r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
      end
    end
    return r[LEN_W-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [WORD_W-1:0] pdata_q, pdata_d;
  logic              cmd_v_q, cmd_v_d;
  logic              pv_q, pv_d;
  logic              done_q, done_d;
  logic              resync_q, resync_d;
  logic              err_len_q, err_len_d;
  logic              err_to_q, err_to_d;
  logic              busy_q, busy_d;

  logic [LEN_W-1:0]  len_w;
  logic [LEN_W-1:0]  cnt_inc;
  logic [TO_W-1:0]   to_inc;

  assign len_w   = len_of(i_word_data);
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign to_inc  = to_cnt_q + TO_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    cmd_d     = cmd_q;
    pdata_d   = pdata_q;
    cmd_v_d   = 1'b0;
    pv_d      = 1'b0;
    done_d    = 1'b0;
    resync_d  = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;

    if (i_word_valid) begin
      // A word in the same cycle the timeout limit would be reached wins.
      to_cnt_d = '0;
      if (i_word_data == RESYNC_WORD) begin
        resync_d = 1'b1;
        state_d  = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_word_data == SOP_WORD) state_d = S_CMD;
          end
          S_CMD: begin
            cmd_d   = i_word_data[CMD_LSB +: CMD_W];
            cmd_v_d = 1'b1;
            state_d = S_LEN;
          end
          S_LEN: begin
            if (len_w == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (33'(len_w) > 33'(MAX_WORDS)) begin
              err_len_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              len_d   = len_w;
              cnt_d   = '0;
              state_d = S_PAYLOAD;
            end
          end
          default: begin
            pdata_d = i_word_data;
            pv_d    = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        endcase
      end
    end else if (state_q != S_IDLE) begin
      if (TO_EN) begin
        if (to_inc == TO_LIMIT) begin
          err_to_d = 1'b1;
          to_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_inc;
        end
      end
    end else begin
      to_cnt_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      cmd_q     <= '0;
      pdata_q   <= '0;
      cmd_v_q   <= 1'b0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
      resync_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      cmd_q     <= cmd_d;
      pdata_q   <= pdata_d;
      cmd_v_q   <= cmd_v_d;
      pv_q      <= pv_d;
      done_q    <= done_d;
      resync_q  <= resync_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      busy_q    <= busy_d;
    end
  end

  assign o_cmd           = cmd_q;
  assign o_cmd_valid     = cmd_v_q;
  assign o_payload_data  = pdata_q;
  assign o_payload_valid = pv_q;
  assign o_packet_done   = done_q;
  assign o_resync        = resync_q;
  assign o_err_len       = err_len_q;
  assign o_err_timeout   = err_to_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_packet_stream_decoder.sv
// Bench for packet_stream_decoder: directed vector table, hand sequences for timeout
// and reset, then random packets checked against a packet-level reference model.
module tb_packet_stream_decoder;

  localparam logic [31:0] RESYNC = 32'h1EDC6F41;
  localparam logic [31:0] SOP    = 32'h741B8CD7;

  logic        clk = 1'b0;
  logic        rst;
  logic        wv;
  logic [31:0] wd;
  logic [1:0]  o_cmd;
  logic        o_cmd_valid;
  logic [31:0] o_payload_data;
  logic        o_payload_valid;
  logic        o_packet_done;
  logic        o_resync;
  logic        o_err_len;
  logic        o_err_timeout;
  logic        o_busy;

  always #5 clk = ~clk;

  packet_stream_decoder #(.TIMEOUT_CYC(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_word_valid   (wv),
    .i_word_data    (wd),
    .o_cmd          (o_cmd),
    .o_cmd_valid    (o_cmd_valid),
    .o_payload_data (o_payload_data),
    .o_payload_valid(o_payload_valid),
    .o_packet_done  (o_packet_done),
    .o_resync       (o_resync),
    .o_err_len      (o_err_len),
    .o_err_timeout  (o_err_timeout),
    .o_busy         (o_busy)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [6:0]  fl;   // {cmd_valid, payload_valid, done, resync, err_len, err_timeout, busy}
    logic [31:0] pd;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    exp_t        e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet progress tracked as "words still owed" and a quiet-cycle run.
  int          m_phase;     // 0 waiting SOP, 1 want command, 2 want length, 3 in payload
  int          m_remaining;
  int          m_quiet;
  logic [1:0]  m_cmd;
  logic [31:0] m_pdata;
  exp_t        mexp;

  function automatic exp_t mke(input logic [1:0] cmd, input logic [6:0] fl, input logic [31:0] pd);
    exp_t e;
    e.cmd = cmd;
    e.fl  = fl;
    e.pd  = pd;
    return e;
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic [1:0] cmd,
                               input logic [6:0] fl, input logic [31:0] pd);
    vec_t r;
    r.v = v;
    r.d = d;
    r.e = mke(cmd, fl, pd);
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_remaining = 0; m_quiet = 0; m_cmd = 2'd0; m_pdata = 32'd0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d);
    int n;
    logic cv, pv, dn, rs, el, et;
    cv = 0; pv = 0; dn = 0; rs = 0; el = 0; et = 0;
    if (v) begin
      m_quiet = 0;
      if (d == RESYNC) begin
        rs = 1; m_phase = 0;
      end else if (m_phase == 0) begin
        if (d == SOP) m_phase = 1;
      end else if (m_phase == 1) begin
        m_cmd = 2'((d >> 24) & 3); cv = 1; m_phase = 2;
      end else if (m_phase == 2) begin
        n = int'((d >> 16) & 255) * 256 + int'((d >> 24) & 255);
        if (n == 0) begin dn = 1; m_phase = 0; end
        else if (n > 4096) begin el = 1; m_phase = 0; end
        else begin m_remaining = n; m_phase = 3; end
      end else begin
        pv = 1; m_pdata = d; m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin dn = 1; m_phase = 0; end
      end
    end else if (m_phase != 0) begin
      m_quiet = m_quiet + 1;
      if (m_quiet == 8) begin et = 1; m_phase = 0; m_quiet = 0; end
    end else begin
      m_quiet = 0;
    end
    mexp = mke(m_cmd, {cv, pv, dn, rs, el, et, (m_phase != 0)}, m_pdata);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    wv = v;
    wd = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    wv = 1'b0;
  endtask

  task automatic check_out(input string name, input exp_t e);
    logic [8:0] act, req;
    act = {o_cmd, o_cmd_valid, o_payload_valid, o_packet_done, o_resync, o_err_len,
           o_err_timeout, o_busy};
    req = {e.cmd, e.fl};
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: {cmd,cv,pv,done,rs,elen,eto,busy} act=%b req=%b", name, act, req);
    end
    if (e.fl[5]) begin
      n_cmp++;
      if (o_payload_data !== e.pd) begin
        n_bad++;
        $display("FAIL %s: payload act=%h req=%h", name, o_payload_data, e.pd);
      end
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({o_cmd, o_cmd_valid, o_payload_valid, o_packet_done, o_resync, o_err_len,
         o_err_timeout, o_busy} !== 9'd0 || o_payload_data !== 32'd0) begin
      n_bad++;
      $display("FAIL %s: outputs act=%b/%h req=0/0", name,
               {o_cmd, o_cmd_valid, o_payload_valid, o_packet_done, o_resync, o_err_len,
                o_err_timeout, o_busy}, o_payload_data);
    end
  endtask

  task automatic rnd_cycle(input logic v, input logic [31:0] d);
    drive(v, d);
    check_out("random", mexp);
  endtask

  task automatic rnd_gap();
    int g;
    g = int'($urandom_range(0, 15));
    if (g >= 12) begin
      g = int'($urandom_range(1, 9));
      for (int k = 0; k < g; k++) rnd_cycle(1'b0, $urandom);
    end
  endtask

  vec_t tbl[$];

  initial begin
    int n, junk, kind, r;
    logic [31:0] w, lw;

    // Directed table: {valid, word, cmd, {cv,pv,done,rs,elen,eto,busy}, payload}
    tbl.push_back(mkv(1, SOP,          2'd0, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h02000000, 2'd2, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h03000000, 2'd2, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'hAAAA0001, 2'd2, 7'b0100001, 32'hAAAA0001));
    tbl.push_back(mkv(1, 32'hBBBB0002, 2'd2, 7'b0100001, 32'hBBBB0002));
    tbl.push_back(mkv(1, 32'hCCCC0003, 2'd2, 7'b0110000, 32'hCCCC0003));
    tbl.push_back(mkv(0, 32'h0,        2'd2, 7'b0000000, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd2, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h01000000, 2'd1, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h00000000, 2'd1, 7'b0010000, 32'h0));
    tbl.push_back(mkv(0, 32'h0,        2'd1, 7'b0000000, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd1, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h03000000, 2'd3, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h01100000, 2'd3, 7'b0000100, 32'h0));
    tbl.push_back(mkv(1, 32'h11111111, 2'd3, 7'b0000000, 32'h0));
    tbl.push_back(mkv(1, 32'h22222222, 2'd3, 7'b0000000, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd3, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h00000000, 2'd0, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h03000000, 2'd0, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h12345678, 2'd0, 7'b0100001, 32'h12345678));
    tbl.push_back(mkv(1, RESYNC,       2'd0, 7'b0001000, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd0, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h02000000, 2'd2, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h01000000, 2'd2, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd2, 7'b0110000, SOP));
    tbl.push_back(mkv(1, SOP,          2'd2, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'h01000000, 2'd1, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h02000000, 2'd1, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'hDEAD0001, 2'd1, 7'b0100001, 32'hDEAD0001));
    tbl.push_back(mkv(1, 32'hDEAD0002, 2'd1, 7'b0110000, 32'hDEAD0002));
    tbl.push_back(mkv(1, RESYNC,       2'd1, 7'b0001000, 32'h0));
    tbl.push_back(mkv(1, SOP,          2'd1, 7'b0000001, 32'h0));
    tbl.push_back(mkv(1, 32'hFDFFFFFF, 2'd1, 7'b1000001, 32'h0));
    tbl.push_back(mkv(1, 32'h0000FFFF, 2'd1, 7'b0010000, 32'h0));

    rst = 1'b1; wv = 1'b0; wd = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d);
      check_out($sformatf("vec%0d", i), tbl[i].e);
    end

    // Timeout after the command word: 8 quiet cycles.
    drive(1, SOP);          check_out("to_sop", mke(2'd1, 7'b0000001, 32'h0));
    drive(1, 32'h02000000); check_out("to_cmd", mke(2'd2, 7'b1000001, 32'h0));
    for (int k = 0; k < 7; k++) begin
      drive(0, $urandom);   check_out("to_wait", mke(2'd2, 7'b0000001, 32'h0));
    end
    drive(0, 32'h0);        check_out("to_fire", mke(2'd2, 7'b0000010, 32'h0));
    drive(0, 32'h0);        check_out("to_after", mke(2'd2, 7'b0000000, 32'h0));

    // Word on the limit cycle beats the timeout.
    drive(1, SOP);          check_out("tp_sop", mke(2'd2, 7'b0000001, 32'h0));
    drive(1, 32'h01000000); check_out("tp_cmd", mke(2'd1, 7'b1000001, 32'h0));
    for (int k = 0; k < 7; k++) begin
      drive(0, 32'h0);      check_out("tp_wait", mke(2'd1, 7'b0000001, 32'h0));
    end
    drive(1, 32'h00000000); check_out("tp_len0", mke(2'd1, 7'b0010000, 32'h0));

    // Timeout inside the payload.
    drive(1, SOP);          check_out("tq_sop", mke(2'd1, 7'b0000001, 32'h0));
    drive(1, 32'h03000000); check_out("tq_cmd", mke(2'd3, 7'b1000001, 32'h0));
    drive(1, 32'h02000000); check_out("tq_len", mke(2'd3, 7'b0000001, 32'h0));
    drive(1, 32'h55550000); check_out("tq_p0", mke(2'd3, 7'b0100001, 32'h55550000));
    for (int k = 0; k < 7; k++) begin
      drive(0, 32'h0);      check_out("tq_wait", mke(2'd3, 7'b0000001, 32'h0));
    end
    drive(0, 32'h0);        check_out("tq_fire", mke(2'd3, 7'b0000010, 32'h0));

    // Asynchronous reset mid-payload.
    drive(1, SOP);          check_out("rs_sop", mke(2'd3, 7'b0000001, 32'h0));
    drive(1, 32'h03000000); check_out("rs_cmd", mke(2'd3, 7'b1000001, 32'h0));
    drive(1, 32'h05000000); check_out("rs_len", mke(2'd3, 7'b0000001, 32'h0));
    drive(1, 32'h77770001); check_out("rs_p0", mke(2'd3, 7'b0100001, 32'h77770001));
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1, SOP);          check_out("ar_sop", mke(2'd0, 7'b0000001, 32'h0));
    drive(1, 32'h01000000); check_out("ar_cmd", mke(2'd1, 7'b1000001, 32'h0));
    drive(1, 32'h01000000); check_out("ar_len", mke(2'd1, 7'b0000001, 32'h0));
    drive(1, 32'hCAFEF00D); check_out("ar_p0", mke(2'd1, 7'b0110000, 32'hCAFEF00D));

    // Randomised traffic against the reference model.
    for (int p = 0; p < 200; p++) begin
      junk = int'($urandom_range(0, 2));
      for (int j = 0; j < junk; j++) rnd_cycle(1'b1, $urandom);
      rnd_cycle(1'b1, SOP);
      rnd_gap();
      rnd_cycle(1'b1, $urandom);
      rnd_gap();
      kind = int'($urandom_range(0, 19));
      if (kind < 2)      n = 4097 + int'($urandom_range(0, 2000));
      else if (kind < 4) n = 0;
      else               n = int'($urandom_range(1, 6));
      lw = {n[7:0], n[15:8], 16'($urandom)};
      rnd_cycle(1'b1, lw);
      if (n <= 4096) begin
        for (int j = 0; j < n; j++) begin
          rnd_gap();
          w = $urandom;
          r = int'($urandom_range(0, 39));
          if (r == 0)      w = RESYNC;
          else if (r == 1) w = SOP;
          rnd_cycle(1'b1, w);
        end
      end
      if ($urandom_range(0, 3) == 0) rnd_cycle(1'b0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
